prod_accumulator: RTL and testbench



---
 rtl/prod_acc_pkg.sv | 14 +
 rtl/prod_accumulator_if.sv | 31 +++
 rtl/prod_accumulator_sat_add_u.sv | 19 +
 rtl/prod_accumulator.sv | 120 ++++++++++++
 tb/tb_prod_accumulator.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prod_acc_pkg.sv
// Shared types and default sizing for the product accumulator.
// Included first so both the interface and the RTL can import it.
package prod_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int P_WIDTH_DEF   = 32;
  localparam int ACC_WIDTH_DEF = 40;
  localparam int LEN_DEF       = 16;

endpackage

// File: rtl/prod_accumulator_if.sv
// Product-in / sum-out handshake bundle for prod_accumulator.
// The slave modport is the accumulator's view; master is the surrounding logic's view.
interface prod_accumulator_if
  import prod_acc_pkg::*;
#(
  parameter int P_WIDTH   = P_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int CNT_W     = $clog2(LEN_DEF + 1)
);

  logic [P_WIDTH-1:0]   p_in;
  logic                 p_valid;
  logic                 p_ready;
  logic                 flush;
  logic [ACC_WIDTH-1:0] sum_out;
  logic [CNT_W-1:0]     sum_count;
  logic                 sum_ovf;
  logic                 sum_valid;
  logic                 sum_ready;

  modport slave (
    input  p_in, p_valid, flush, sum_ready,
    output p_ready, sum_out, sum_count, sum_ovf, sum_valid
  );

  modport master (
    output p_in, p_valid, flush, sum_ready,
    input  p_ready, sum_out, sum_count, sum_ovf, sum_valid
  );

endinterface

// File: rtl/prod_accumulator_sat_add_u.sv
// Unsigned accumulator adder: acc + zero-extended product, clamped to all ones
// when the add carries out of ACC_WIDTH.
module sat_add_u #(
  parameter int P_WIDTH   = 32,
  parameter int ACC_WIDTH = 40
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  input  logic [P_WIDTH-1:0]   i_p,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_ovf
);

  logic [ACC_WIDTH:0] w_raw;

  assign w_raw = {1'b0, i_acc} + {{(ACC_WIDTH + 1 - P_WIDTH){1'b0}}, i_p};
  assign o_ovf = w_raw[ACC_WIDTH];
  assign o_sum = o_ovf ? {ACC_WIDTH{1'b1}} : w_raw[ACC_WIDTH-1:0];

endmodule

// File: rtl/prod_accumulator.sv
// Dot-product accumulator: sums up to LEN products (or fewer on flush) and
// holds each result on a valid/ready port, stalling the product stream meanwhile.
//
// state | meaning
// ACCUM | accepting products, p_ready=1
// HOLD  | result presented, waiting for sum_ready
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int P_WIDTH   = P_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int LEN       = LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  prod_accumulator_if.slave   bus
);

  localparam int CNT_W = $clog2(LEN + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_acc_ovf;
  logic [ACC_WIDTH-1:0] r_sum_out;
  logic [CNT_W-1:0]     r_sum_count;
  logic                 r_sum_ovf;

  logic                 w_in_accum;
  logic                 w_accept;
  logic                 w_close;
  logic                 w_last_term;
  logic [ACC_WIDTH-1:0] w_add_sum;
  logic                 w_add_ovf;
  logic [ACC_WIDTH-1:0] w_next_acc;
  logic                 w_next_ovf;
  logic [CNT_W-1:0]     w_next_cnt;
  logic                 w_p_ready;
  logic                 w_sum_valid;

  sat_add_u #(
    .P_WIDTH   (P_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat_add (
    .i_acc (r_acc),
    .i_p   (bus.p_in),
    .o_sum (w_add_sum),
    .o_ovf (w_add_ovf)
  );

  assign w_in_accum  = (r_state == ACCUM);
  assign w_accept    = bus.p_valid && w_in_accum;
  assign w_last_term = (r_cnt == CNT_W'(LEN - 1));

  assign w_next_acc = w_accept ? w_add_sum : r_acc;
  assign w_next_ovf = r_acc_ovf | (w_accept & w_add_ovf);
  assign w_next_cnt = r_cnt + CNT_W'(w_accept);

  // An idle flush with nothing accumulated is dropped so no empty sums appear.
  assign w_close = w_in_accum &&
                   ((w_accept && w_last_term) ||
                    (bus.flush && ((r_cnt != '0) || w_accept)));

  always_comb begin
    w_state_nxt = r_state;
    w_p_ready   = 1'b0;
    w_sum_valid = 1'b0;
    case (r_state)
      ACCUM: begin
        w_p_ready = 1'b1;
        if (w_close) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_sum_valid = 1'b1;
        if (bus.sum_ready) begin
          w_state_nxt = ACCUM;
        end
      end
      default: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_acc_ovf   <= 1'b0;
      r_sum_out   <= '0;
      r_sum_count <= '0;
      r_sum_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_close) begin
        r_sum_out   <= w_next_acc;
        r_sum_count <= w_next_cnt;
        r_sum_ovf   <= w_next_ovf;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_acc_ovf   <= 1'b0;
      end else if (w_accept) begin
        r_acc     <= w_next_acc;
        r_cnt     <= w_next_cnt;
        r_acc_ovf <= w_next_ovf;
      end
    end
  end

  assign bus.p_ready   = w_p_ready;
  assign bus.sum_valid = w_sum_valid;
  assign bus.sum_out   = r_sum_out;
  assign bus.sum_count = r_sum_count;
  assign bus.sum_ovf   = r_sum_ovf;

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: directed scenarios on three parameterisations
// plus a randomized run against a queue-based reference model.
module tb_prod_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  // A: LEN=4, narrow accumulator so saturation is reachable
  prod_accumulator_if #(.P_WIDTH(32), .ACC_WIDTH(33), .CNT_W(3)) ifa ();
  // B: defaults
  prod_accumulator_if #(.P_WIDTH(32), .ACC_WIDTH(40), .CNT_W(5)) ifb ();
  // C: LEN=1
  prod_accumulator_if #(.P_WIDTH(32), .ACC_WIDTH(40), .CNT_W(1)) ifc ();

  prod_accumulator #(.P_WIDTH(32), .ACC_WIDTH(33), .LEN(4)) u_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  prod_accumulator #(.P_WIDTH(32), .ACC_WIDTH(40), .LEN(16)) u_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );
  prod_accumulator #(.P_WIDTH(32), .ACC_WIDTH(40), .LEN(1)) u_c (
    .clk (clk), .rst (rst), .bus (ifc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.p_valid = 0; ifa.p_in = '0; ifa.flush = 0; ifa.sum_ready = 0;
    ifb.p_valid = 0; ifb.p_in = '0; ifb.flush = 0; ifb.sum_ready = 0;
    ifc.p_valid = 0; ifc.p_in = '0; ifc.flush = 0; ifc.sum_ready = 0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1;
    tick(); tick();
    rst = 0;
    n_checks++;
    if ({ifa.sum_valid, ifa.sum_out, ifa.sum_count, ifa.sum_ovf} !== '0 || ifa.p_ready !== 1'b1)
      $display("FAIL reset_a: valid=%0b out=%h cnt=%0d ovf=%0b rdy=%0b, want 0/0/0/0/1",
               ifa.sum_valid, ifa.sum_out, ifa.sum_count, ifa.sum_ovf, ifa.p_ready);
    else n_pass++;
    n_checks++;
    if ({ifb.sum_valid, ifb.sum_out, ifb.sum_count, ifb.sum_ovf} !== '0 || ifb.p_ready !== 1'b1)
      $display("FAIL reset_b: valid=%0b out=%h cnt=%0d rdy=%0b, want 0/0/0/1",
               ifb.sum_valid, ifb.sum_out, ifb.sum_count, ifb.p_ready);
    else n_pass++;
    n_checks++;
    if ({ifc.sum_valid, ifc.sum_out, ifc.sum_count, ifc.sum_ovf} !== '0 || ifc.p_ready !== 1'b1)
      $display("FAIL reset_c: valid=%0b out=%h rdy=%0b, want 0/0/1",
               ifc.sum_valid, ifc.sum_out, ifc.p_ready);
    else n_pass++;
  endtask

  task automatic test_basic_len4();
    ifa.sum_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      ifa.p_valid = 1; ifa.p_in = k;
      n_checks++;
      if (ifa.p_ready !== 1'b1 || ifa.sum_valid !== 1'b0)
        $display("FAIL basic_accum_rdy: rdy=%0b valid=%0b, want 1/0", ifa.p_ready, ifa.sum_valid);
      else n_pass++;
      tick();
    end
    ifa.p_valid = 0;
    n_checks++;
    if (ifa.sum_valid !== 1'b1 || ifa.sum_out !== 33'd10 || ifa.sum_count !== 3'd4 ||
        ifa.sum_ovf !== 1'b0 || ifa.p_ready !== 1'b0)
      $display("FAIL basic_sum: valid=%0b out=%0d cnt=%0d ovf=%0b rdy=%0b, want 1/10/4/0/0",
               ifa.sum_valid, ifa.sum_out, ifa.sum_count, ifa.sum_ovf, ifa.p_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (ifa.p_ready !== 1'b1 || ifa.sum_valid !== 1'b0)
      $display("FAIL basic_one_bubble: rdy=%0b valid=%0b, want 1/0", ifa.p_ready, ifa.sum_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    ifa.sum_ready = 0;
    for (int k = 0; k < 4; k++) begin
      ifa.p_valid = 1; ifa.p_in = 1;
      tick();
    end
    ifa.p_in = 7;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (ifa.sum_valid !== 1'b1 || ifa.sum_out !== 33'd4 || ifa.sum_count !== 3'd4 ||
          ifa.p_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: valid=%0b out=%0d cnt=%0d rdy=%0b, want 1/4/4/0",
                 k, ifa.sum_valid, ifa.sum_out, ifa.sum_count, ifa.p_ready);
      else n_pass++;
    end
    ifa.sum_ready = 1;
    tick();
    ifa.p_in = 5; ifa.flush = 1;
    tick();
    ifa.p_valid = 0; ifa.flush = 0;
    n_checks++;
    if (ifa.sum_valid !== 1'b1 || ifa.sum_out !== 33'd5 || ifa.sum_count !== 3'd1)
      $display("FAIL bp_fresh_sum: valid=%0b out=%0d cnt=%0d, want 1/5/1",
               ifa.sum_valid, ifa.sum_out, ifa.sum_count);
    else n_pass++;
    tick();
  endtask

  task automatic test_wide_flush();
    ifb.sum_ready = 1;
    ifb.p_valid = 1; ifb.p_in = 32'hFFFF_FFFF;
    tick();
    ifb.flush = 1;
    tick();
    ifb.p_valid = 0; ifb.flush = 0;
    n_checks++;
    if (ifb.sum_valid !== 1'b1 || ifb.sum_out !== 40'h01_FFFF_FFFE || ifb.sum_count !== 5'd2 ||
        ifb.sum_ovf !== 1'b0)
      $display("FAIL wide_flush: valid=%0b out=%h cnt=%0d ovf=%0b, want 1/01fffffffe/2/0",
               ifb.sum_valid, ifb.sum_out, ifb.sum_count, ifb.sum_ovf);
    else n_pass++;
    tick();
    ifb.flush = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (ifb.sum_valid !== 1'b0 || ifb.p_ready !== 1'b1)
        $display("FAIL empty_flush[%0d]: valid=%0b rdy=%0b, want 0/1", k, ifb.sum_valid, ifb.p_ready);
      else n_pass++;
    end
    ifb.flush = 0;
  endtask

  task automatic test_saturation();
    ifa.sum_ready = 0;
    for (int k = 0; k < 3; k++) begin
      ifa.p_valid = 1; ifa.p_in = 32'hFFFF_FFFF;
      tick();
    end
    ifa.p_valid = 0; ifa.flush = 1;
    tick();
    ifa.flush = 0;
    n_checks++;
    if (ifa.sum_valid !== 1'b1 || ifa.sum_out !== 33'h1_FFFF_FFFF || ifa.sum_ovf !== 1'b1 ||
        ifa.sum_count !== 3'd3)
      $display("FAIL sat_clamp: valid=%0b out=%h ovf=%0b cnt=%0d, want 1/1ffffffff/1/3",
               ifa.sum_valid, ifa.sum_out, ifa.sum_ovf, ifa.sum_count);
    else n_pass++;
    ifa.sum_ready = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      ifa.p_valid = 1; ifa.p_in = 1;
      tick();
    end
    ifa.p_valid = 0;
    n_checks++;
    if (ifa.sum_valid !== 1'b1 || ifa.sum_out !== 33'd4 || ifa.sum_ovf !== 1'b0 ||
        ifa.sum_count !== 3'd4)
      $display("FAIL sat_cleared: valid=%0b out=%0d ovf=%0b cnt=%0d, want 1/4/0/4",
               ifa.sum_valid, ifa.sum_out, ifa.sum_ovf, ifa.sum_count);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    ifa.sum_ready = 1;
    ifa.p_valid = 1; ifa.p_in = 5;
    tick(); tick();
    ifa.p_valid = 0;
    rst = 1;
    tick();
    n_checks++;
    if (ifa.sum_valid !== 1'b0 || ifa.sum_out !== '0 || ifa.sum_count !== '0 ||
        ifa.sum_ovf !== 1'b0 || ifa.p_ready !== 1'b1)
      $display("FAIL rst_mid_clear: valid=%0b out=%0d cnt=%0d ovf=%0b rdy=%0b, want 0/0/0/0/1",
               ifa.sum_valid, ifa.sum_out, ifa.sum_count, ifa.sum_ovf, ifa.p_ready);
    else n_pass++;
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      ifa.p_valid = 1; ifa.p_in = 1;
      tick();
      if (k < 3) begin
        n_checks++;
        if (ifa.sum_valid !== 1'b0)
          $display("FAIL rst_mid_early[%0d]: valid=%0b, want 0", k, ifa.sum_valid);
        else n_pass++;
      end
    end
    ifa.p_valid = 0;
    n_checks++;
    if (ifa.sum_valid !== 1'b1 || ifa.sum_out !== 33'd4 || ifa.sum_count !== 3'd4)
      $display("FAIL rst_mid_sum: valid=%0b out=%0d cnt=%0d, want 1/4/4",
               ifa.sum_valid, ifa.sum_out, ifa.sum_count);
    else n_pass++;
    tick();
  endtask

  task automatic test_len1();
    ifc.sum_ready = 1; ifc.p_valid = 1; ifc.p_in = 3;
    for (int k = 0; k < 8; k++) begin
      logic hold;
      tick();
      hold = ((k % 2) == 0);
      n_checks++;
      if (ifc.sum_valid !== hold || ifc.p_ready !== !hold ||
          (hold && (ifc.sum_out !== 40'd3 || ifc.sum_count !== 1'b1)))
        $display("FAIL len1[%0d]: valid=%0b rdy=%0b out=%0d cnt=%0d, want valid=%0b rdy=%0b out=3 cnt=1",
                 k, ifc.sum_valid, ifc.p_ready, ifc.sum_out, ifc.sum_count, hold, !hold);
      else n_pass++;
    end
    ifc.p_valid = 0;
    tick();
  endtask

  // Reference: a sum is the list of accepted terms; it closes at LEN terms or
  // on flush with at least one term, and the result saturates at 2^33-1.
  task automatic test_random();
    longint unsigned terms[$];
    longint unsigned total;
    longint unsigned max_val = (64'd1 << 33) - 1;
    logic            m_hold = 0;
    logic [32:0]     e_sum  = '0;
    logic [2:0]      e_cnt  = '0;
    logic            e_ovf  = 0;
    int              n_sums = 0;

    idle_all();
    rst = 1;
    tick();
    rst = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ifa.p_valid   = ($urandom_range(0, 3) != 0);
      ifa.p_in      = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1000);
      ifa.flush     = ($urandom_range(0, 4) == 0);
      ifa.sum_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      n_checks++;
      if (ifa.p_ready !== !m_hold || ifa.sum_valid !== m_hold)
        $display("FAIL rnd_hs[%0d]: rdy=%0b valid=%0b, want %0b/%0b",
                 cyc, ifa.p_ready, ifa.sum_valid, !m_hold, m_hold);
      else n_pass++;
      if (m_hold) begin
        n_checks++;
        if (ifa.sum_out !== e_sum || ifa.sum_count !== e_cnt || ifa.sum_ovf !== e_ovf)
          $display("FAIL rnd_sum[%0d]: out=%h cnt=%0d ovf=%0b, want %h/%0d/%0b",
                   cyc, ifa.sum_out, ifa.sum_count, ifa.sum_ovf, e_sum, e_cnt, e_ovf);
        else n_pass++;
        if (ifa.sum_ready) m_hold = 0;
      end else begin
        if (ifa.p_valid) terms.push_back(longint'(ifa.p_in));
        if (terms.size() == 4 || (ifa.flush && terms.size() > 0)) begin
          total = 0;
          foreach (terms[j]) total += terms[j];
          e_ovf = (total > max_val);
          e_sum = e_ovf ? 33'(max_val) : 33'(total);
          e_cnt = 3'(terms.size());
          terms.delete();
          m_hold = 1;
          n_sums++;
        end
      end
      tick();
    end
    idle_all();
    n_checks++;
    if (n_sums < 20)
      $display("FAIL rnd_activity: sums=%0d, want >= 20", n_sums);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_len4();
    test_backpressure();
    test_wide_flush();
    test_saturation();
    test_reset_mid();
    test_len1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
